// File: rtl/meikyuu_pkg.sv
// Shared types and constants for the button front end: FSM states, direction indices
// and the frame counter width.
package meikyuu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPending,
    StDelay,
    StRepeat,
    StHeld
  } btn_state_e;

  localparam int unsigned UP    = 0;
  localparam int unsigned DOWN  = 1;
  localparam int unsigned LEFT  = 2;
  localparam int unsigned RIGHT = 3;

  localparam int unsigned FRAME_CNT_W = 8;

endpackage

// File: rtl/btn_channel.sv
// One push-button: 2-flop synchronizer, debounce and press FSM.
// Auto-repeat is built only when BTN_FILTER_AUTOREPEAT_EN is defined.
module btn_channel
  import meikyuu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic CLOCK_25,
  input  logic reset,
  input  logic i_btn_raw,
  input  logic i_frame_tick,
  output logic o_stable,
  output logic o_strobe
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_cfg_check
    $error("btn_channel: parameter out of range");
  end

  localparam logic RawReleased = (BTN_ACTIVE_LOW != 0);
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_db_cnt;
  logic            r_stable;
  btn_state_e      r_state, w_state_d;
  logic            w_pressed, w_differ, w_toggle, w_rise, w_fall;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_sync <= {2{RawReleased}};
    end else begin
      r_sync <= {r_sync[0], i_btn_raw};
    end
  end

  assign w_pressed = r_sync[1] ^ RawReleased;
  assign w_differ  = (w_pressed != r_stable);
  assign w_toggle  = w_differ && (r_db_cnt == CntMax);
  assign w_rise    = w_toggle && !r_stable;
  assign w_fall    = w_toggle && r_stable;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_stable <= 1'b0;
    end else begin
      if (!w_differ || w_toggle) r_db_cnt <= '0;
      else                       r_db_cnt <= r_db_cnt + CntW'(1);
      if (w_toggle) r_stable <= ~r_stable;
    end
  end

  assign o_stable = r_stable;

`ifdef BTN_FILTER_AUTOREPEAT_EN
  localparam logic [FRAME_CNT_W-1:0] DelayTicks = FRAME_CNT_W'(REPEAT_DELAY);
  localparam logic [FRAME_CNT_W-1:0] RateTicks  = FRAME_CNT_W'(REPEAT_RATE);

  logic [FRAME_CNT_W-1:0] r_frame, w_frame_inc, w_frame_d;

  assign w_frame_inc = (r_frame == '1) ? r_frame : r_frame + FRAME_CNT_W'(1);

  // Restart the frame count on every state change and every strobe.
  always_comb begin
    w_frame_d = r_frame;
    if (w_state_d != r_state || o_strobe) w_frame_d = '0;
    else if (i_frame_tick)                w_frame_d = w_frame_inc;
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) r_frame <= '0;
    else       r_frame <= w_frame_d;
  end
`endif

  // Release wins over everything; a rising edge is taken before any tick in IDLE.
  always_comb begin
    w_state_d = r_state;
    o_strobe  = 1'b0;
    if (w_fall) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_rise) w_state_d = StPending;
        end
        StPending: begin
          if (i_frame_tick) begin
            o_strobe = 1'b1;
`ifdef BTN_FILTER_AUTOREPEAT_EN
            w_state_d = StDelay;
`else
            w_state_d = StHeld;
`endif
          end
        end
`ifdef BTN_FILTER_AUTOREPEAT_EN
        StDelay: begin
          if (i_frame_tick && w_frame_inc == DelayTicks) begin
            o_strobe  = 1'b1;
            w_state_d = StRepeat;
          end
        end
        StRepeat: begin
          if (i_frame_tick && w_frame_inc == RateTicks) o_strobe = 1'b1;
        end
`else
        StHeld: begin
          w_state_d = StHeld;
        end
`endif
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

endmodule

// File: rtl/btn_filter.sv
// Four debounced buttons turned into registered one-cycle move strobes, with
// opposite-direction cancellation. Auto-repeat is enabled by BTN_FILTER_AUTOREPEAT_EN.
module btn_filter
  import meikyuu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_RATE     = 4,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [3:0] held
);

  logic [3:0] w_raw, w_stable, w_qual, w_go;
  logic [3:0] r_move;

  assign w_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < 4; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_channel (
      .CLOCK_25    (CLOCK_25),
      .reset       (reset),
      .i_btn_raw   (w_raw[g]),
      .i_frame_tick(frame_tick),
      .o_stable    (w_stable[g]),
      .o_strobe    (w_qual[g])
    );
  end

  // Opposite directions qualifying together cancel; the channel FSMs still advance.
  always_comb begin
    w_go = w_qual;
    if (w_qual[UP] && w_qual[DOWN]) begin
      w_go[UP]   = 1'b0;
      w_go[DOWN] = 1'b0;
    end
    if (w_qual[LEFT] && w_qual[RIGHT]) begin
      w_go[LEFT]  = 1'b0;
      w_go[RIGHT] = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) r_move <= '0;
    else       r_move <= w_go;
  end

  assign move_up    = r_move[UP];
  assign move_down  = r_move[DOWN];
  assign move_left  = r_move[LEFT];
  assign move_right = r_move[RIGHT];
  assign held       = w_stable;

endmodule

// File: tb/tb_btn_filter.sv
// Directed bench for btn_filter with DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2,
// active-low buttons; expectations follow BTN_FILTER_AUTOREPEAT_EN.
module tb_btn_filter;

  logic       CLOCK_25 = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] press = 4'b0000;  // active-high press mask {right, left, down, up}
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       move_up, move_down, move_left, move_right;
  logic [3:0] held;
  logic [3:0] w_move;

  assign btn_up    = ~press[0];
  assign btn_down  = ~press[1];
  assign btn_left  = ~press[2];
  assign btn_right = ~press[3];
  assign w_move    = {move_right, move_left, move_down, move_up};

  always #5 CLOCK_25 = ~CLOCK_25;

  btn_filter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (3),
    .REPEAT_RATE    (2),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .CLOCK_25  (CLOCK_25),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .frame_tick(frame_tick),
    .move_up   (move_up),
    .move_down (move_down),
    .move_left (move_left),
    .move_right(move_right),
    .held      (held)
  );

`ifdef BTN_FILTER_AUTOREPEAT_EN
  localparam logic [3:0] ArUp = 4'b0001;
  localparam int RepeatPulses = 5;
`else
  localparam logic [3:0] ArUp = 4'b0000;
  localparam int RepeatPulses = 1;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] press;
    logic       tick;
    logic [3:0] held;
    logic [3:0] move;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic [3:0] p, input logic t, input logic r);
    press      = p;
    frame_tick = t;
    reset      = r;
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] p, input logic t,
                     input logic [3:0] h, input logic [3:0] m);
    vec_t v;
    v.rst = r; v.press = p; v.tick = t; v.held = h; v.move = m;
    tbl.push_back(v);
  endtask

  task automatic settle(input logic [3:0] p, input string name);
    for (int i = 0; i < 8; i++) begin
      cycle(p, 1'b0, 1'b0);
      check({name, "_quiet"}, {28'd0, w_move}, 32'd0);
    end
    check({name, "_held"}, {28'd0, held}, {28'd0, p});
  endtask

  initial begin
    int pulses;
    // Single up press: debounce timing, tick-on-edge, strobes, release.
    add(1, 4'h0, 0, 4'h0, 4'h0);
    for (int i = 1; i <= 5; i++) add(0, 4'h1, 0, 4'h0, 4'h0);
    add(0, 4'h1, 1, 4'h1, 4'h0);   // tick on the stable edge: no strobe
    add(0, 4'h1, 0, 4'h1, 4'h0);
    add(0, 4'h1, 1, 4'h1, 4'h1);   // tick 1
    add(0, 4'h1, 0, 4'h1, 4'h0);
    add(0, 4'h1, 1, 4'h1, 4'h0);   // tick 2
    add(0, 4'h1, 1, 4'h1, 4'h0);   // tick 3
    add(0, 4'h1, 1, 4'h1, ArUp);   // tick 4
    add(0, 4'h1, 0, 4'h1, 4'h0);
    add(0, 4'h1, 1, 4'h1, 4'h0);   // tick 5
    add(0, 4'h1, 1, 4'h1, ArUp);   // tick 6
    add(0, 4'h1, 0, 4'h1, 4'h0);
    add(0, 4'h1, 1, 4'h1, 4'h0);   // tick 7
    add(0, 4'h1, 1, 4'h1, ArUp);   // tick 8
    add(0, 4'h0, 0, 4'h1, 4'h0);   // release
    add(0, 4'h0, 0, 4'h1, 4'h0);
    add(0, 4'h0, 1, 4'h1, 4'h0);
    add(0, 4'h0, 0, 4'h1, 4'h0);
    add(0, 4'h0, 0, 4'h1, 4'h0);
    add(0, 4'h0, 0, 4'h0, 4'h0);   // debounced release
    add(0, 4'h0, 1, 4'h0, 4'h0);
    add(0, 4'h0, 0, 4'h0, 4'h0);
    // Glitch of 3 cycles is rejected.
    for (int i = 0; i < 3; i++) add(0, 4'h1, 0, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) add(0, 4'h0, (i % 2 == 1), 4'h0, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].press, tbl[i].tick, tbl[i].rst);
      check($sformatf("vec%0d_held", i), {28'd0, held}, {28'd0, tbl[i].held});
      check($sformatf("vec%0d_move", i), {28'd0, w_move}, {28'd0, tbl[i].move});
    end

    // Up and down together: never strobe.
    settle(4'b0011, "conflict_ud");
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0011, (i % 2 == 0), 1'b0);
      check($sformatf("conflict_ud_tick%0d", i), {28'd0, w_move}, 32'd0);
    end
    settle(4'b0000, "release_ud");

    // Up and left together: same-cycle strobes.
    settle(4'b0101, "ortho");
    cycle(4'b0101, 1'b1, 1'b0);
    check("ortho_strobe", {28'd0, w_move}, 32'h5);
    cycle(4'b0101, 1'b0, 1'b0);
    check("ortho_one_cycle", {28'd0, w_move}, 32'h0);
    settle(4'b0000, "release_ortho");

    // Right held, reset in DELAY together with a tick.
    settle(4'b1000, "rst_press");
    cycle(4'b1000, 1'b1, 1'b0);
    check("rst_first_strobe", {28'd0, w_move}, 32'h8);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b1000, 1'b1, 1'b0);
    cycle(4'b1000, 1'b1, 1'b0);
    cycle(4'b1000, 1'b1, 1'b1);
    check("rst_held", {28'd0, held}, 32'h0);
    check("rst_move", {28'd0, w_move}, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      cycle(4'b1000, (c == 3), 1'b0);
      check($sformatf("redeb%0d_move", c), {28'd0, w_move}, 32'h0);
      check($sformatf("redeb%0d_held", c), {28'd0, held}, (c == 6) ? 32'h8 : 32'h0);
    end
    cycle(4'b1000, 1'b1, 1'b0);
    check("rearm_strobe", {28'd0, w_move}, 32'h8);
    cycle(4'b1000, 1'b0, 1'b0);
    check("rearm_one_cycle", {28'd0, w_move}, 32'h0);
    settle(4'b0000, "release_right");

    // Left held for 10 frames: count pulses.
    settle(4'b0100, "rep_press");
    pulses = 0;
    for (int f = 0; f < 10; f++) begin
      cycle(4'b0100, 1'b1, 1'b0);
      if (move_left) pulses++;
      cycle(4'b0100, 1'b0, 1'b0);
      if (move_left) pulses++;
    end
    check("left_pulse_count", pulses, RepeatPulses);
    settle(4'b0000, "release_left");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_filter.md
BTN_FILTER -- requirements
Module: btn_filter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable CLOCK_25 cycles needed to accept a level change (10 ms).
REQ-002 Parameter REPEAT_DELAY, default 20, frames from the first strobe to the first auto-repeat strobe.
REQ-003 Parameter REPEAT_RATE, default 4, frames between later auto-repeat strobes.
REQ-004 Parameter BTN_ACTIVE_LOW, default 1; when 1, a raw 0 means pressed.
REQ-005 Port CLOCK_25, input, 1 bit: the only clock.
REQ-006 Port reset, input, 1 bit: synchronous, active-high.
REQ-007 Ports btn_up, btn_down, btn_left, btn_right, input, 1 bit each: raw asynchronous push-buttons.
REQ-008 Port frame_tick, input, 1 bit: one-cycle pulse per frame, issued by the VGA timing stage when v_counter wraps.
REQ-009 Ports move_up, move_down, move_left, move_right, output, 1 bit each: one-cycle move strobes to the player stage.
REQ-010 Port held, output, 4 bits: debounced pressed level, bit order {right, left, down, up}.

Function
REQ-011 Each raw button passes through a 2-flop synchronizer, then polarity normalisation per BTN_ACTIVE_LOW.
REQ-012 Debounce is per button: a counter increments while the synchronized value differs from the stable value and clears when they match.
REQ-013 The stable value toggles, and the counter clears, on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-014 Each button has its own FSM with states IDLE, PENDING, DELAY and REPEAT.
REQ-015 FSM transitions:
- IDLE -> PENDING on the stable rising edge.
- PENDING -> DELAY on frame_tick; a strobe is issued.
- DELAY -> REPEAT after REPEAT_DELAY frame_ticks; a strobe is issued.
- REPEAT issues a strobe every REPEAT_RATE frame_ticks.
- Any state -> IDLE on stable release, the same cycle.
REQ-016 A press released before its frame_tick, i.e. while still in PENDING, produces no strobe.
REQ-017 move_* is registered: asserted exactly one cycle, the cycle after the frame_tick that qualifies it; never asserted without a preceding frame_tick.
REQ-018 Opposite-direction conflict: if up and down qualify on the same frame_tick, neither strobes; the same applies to left and right. Both FSMs still advance.
REQ-019 Orthogonal strobes (for example up and left) may be asserted together.
REQ-020 Frame counters are 8 bits and saturate; REPEAT_DELAY and REPEAT_RATE are in the range 1..255.
REQ-021 frame_tick arriving in the same cycle as a stable edge: the edge is processed first, so the press becomes PENDING and does not strobe on that tick.
REQ-022 held reflects the debounced stable value with no frame alignment.

Reset
REQ-023 On reset, all of the following clear: synchronizers to released, stable values to released, debounce counters, frame counters, FSMs to IDLE, move_* and held.
REQ-024 A button held through reset is treated as a new press and must debounce DEBOUNCE_CYCLES again before entering PENDING.
REQ-025 Reset asserted mid-operation takes priority over every other event in that cycle.

Configuration
REQ-026 Macro BTN_FILTER_AUTOREPEAT_EN controls auto-repeat.
- Defined: DELAY and REPEAT behave as in REQ-015.
- Undefined: DELAY and REPEAT are replaced by a HELD state that emits no strobes, so exactly one strobe per press; REPEAT_DELAY and REPEAT_RATE are ignored.

Structure
REQ-027 Package meikyuu_pkg holds:
- the FSM state enum
- direction index constants (UP=0, DOWN=1, LEFT=2, RIGHT=3)
- the frame counter width constant.
REQ-028 Sub-module btn_channel (synchronizer, debounce and FSM for one button) is instantiated four times. The conflict resolution and output registers live in btn_filter.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2, BTN_ACTIVE_LOW=1.
REQ-029 btn_up low for 3 cycles, then high -> held stays 0, no strobe.
REQ-030 btn_up low, held -> held[0]=1 after 2+4 cycles; with auto-repeat enabled, move_up pulses on ticks 1, 4, 6 and 8.
REQ-031 btn_up and btn_down pressed together -> no move_up and no move_down on any tick; held=4'b0011.
REQ-032 btn_up and btn_left pressed together -> move_up and move_left pulse in the same cycle.
REQ-033 Press btn_right, assert reset for 1 cycle while held in DELAY -> all outputs 0 the next cycle, and move_right reappears only after re-debounce plus the next frame_tick.
REQ-034 Rebuild without BTN_FILTER_AUTOREPEAT_EN and hold btn_left for 10 frames -> exactly one move_left pulse.
